// File: rtl/cntdown_pkg.sv
// Shared state codes and width helper for the countdown sequencer.
// Build option: CNTDOWN_PAUSE_EN enables the PAUSE state.
package cntdown_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_ALARM = 2'd3;

  // bits needed to hold 0..n-1
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cntdown_ctrl_btn_cond.sv
// Pushbutton conditioner: 2-flop sync, stability debounce,
// rising-edge pulse.
module btn_cond
  import cntdown_pkg::*;
#(
  parameter int DEB_LEN = 500000
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic BTN,
  output logic PULSE
);

  localparam int DW = cw(DEB_LEN);

  logic          s1, s2;
  logic          acc, acc_q;
  logic [DW-1:0] cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      acc   <= 1'b0;
      acc_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= BTN;
      s2    <= s1;
      acc_q <= acc;
      if (s2 == acc) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_LEN - 1)) begin
        acc <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  assign PULSE = acc & ~acc_q;

endmodule

// File: rtl/cntdown_ctrl.sv
// Countdown timer sequencer: IDLE/RUN/PAUSE/ALARM control, prescaler.
// Build option: CNTDOWN_PAUSE_EN enables START-to-pause while running.
module cntdown_ctrl
  import cntdown_pkg::*;
#(
  parameter int DIV         = 50000000,
  parameter int DEB_LEN     = 500000,
  parameter int ALARM_TICKS = 10
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic       CLR,
  input  logic [3:0] CNT,
  output logic       LD,
  output logic       EN,
  output logic       BUZZ,
  output logic       RUNNING
);

  localparam int PW = cw(DIV);
  localparam int AW = cw(ALARM_TICKS);

  state_t        st, st_n;
  logic [PW-1:0] ps;
  logic [AW-1:0] ac;
  logic          start_p, clr_p;
  logic          tick, zero, last;

  btn_cond #(.DEB_LEN(DEB_LEN)) u_start (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .BTN   (START),
    .PULSE (start_p)
  );

  btn_cond #(.DEB_LEN(DEB_LEN)) u_clr (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .BTN   (CLR),
    .PULSE (clr_p)
  );

  // prescaler also paces the alarm ticks
  assign tick = (st == ST_RUN || st == ST_ALARM)
             && (ps == PW'(DIV - 1));
  assign zero = (CNT == 4'd0);
  assign last = (ac == AW'(ALARM_TICKS - 1));

  always_comb begin
    st_n = st;
    if (clr_p) begin
      st_n = ST_IDLE;
    end else begin
      unique case (st)
        ST_IDLE:
          if (start_p) st_n = ST_RUN;
`ifdef CNTDOWN_PAUSE_EN
        ST_RUN:
          if (start_p)          st_n = ST_PAUSE;
          else if (tick && zero) st_n = ST_ALARM;
        ST_PAUSE:
          if (start_p) st_n = ST_RUN;
`else
        ST_RUN:
          if (tick && zero) st_n = ST_ALARM;
`endif
        ST_ALARM:
          if (start_p)          st_n = ST_IDLE;
          else if (tick && last) st_n = ST_IDLE;
        default:
          st_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      st      <= ST_IDLE;
      ps      <= '0;
      ac      <= '0;
      LD      <= 1'b1;
      EN      <= 1'b0;
      BUZZ    <= 1'b0;
      RUNNING <= 1'b0;
    end else begin
      st      <= st_n;
      LD      <= (st_n == ST_IDLE);
      RUNNING <= (st_n == ST_RUN);
      EN      <= (st == ST_RUN) && tick && !zero && !clr_p;

      if (st_n == ST_IDLE || st == ST_IDLE)
        ps <= '0;
      else if (st == ST_RUN || st == ST_ALARM)
        ps <= tick ? '0 : ps + PW'(1);

      if (st_n != ST_ALARM || st != ST_ALARM)
        ac <= '0;
      else if (tick)
        ac <= ac + AW'(1);

      if (st_n != ST_ALARM)
        BUZZ <= 1'b0;
      else if (st != ST_ALARM)
        BUZZ <= 1'b1;
      else if (tick)
        BUZZ <= ~BUZZ;
    end
  end

endmodule

// File: tb/tb_cntdown_ctrl.sv
// Bench for cntdown_ctrl: directed scenarios plus random button
// traffic, checked each cycle against a rule-level model.
module tb_cntdown_ctrl;

  localparam int DIV         = 4;
  localparam int DEB_LEN     = 2;
  localparam int ALARM_TICKS = 3;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic       CLR   = 1'b0;
  logic [3:0] cnt_m = 4'd0;
  logic       LD, EN, BUZZ, RUNNING;

  cntdown_ctrl #(
    .DIV         (DIV),
    .DEB_LEN     (DEB_LEN),
    .ALARM_TICKS (ALARM_TICKS)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .START   (START),
    .CLR     (CLR),
    .CNT     (cnt_m),
    .LD      (LD),
    .EN      (EN),
    .BUZZ    (BUZZ),
    .RUNNING (RUNNING)
  );

  always #5 CLOCK = ~CLOCK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [3:0] rsw = 4'd3;

  // model: modes 0 idle, 1 run, 2 pause, 3 alarm
  int   md      = 0;
  int   run_clk = 0;
  int   alm_clk = 0;
  logic e_ld = 1'b1, e_en = 1'b0, e_bz = 1'b0, e_rn = 1'b0;

  // button model per input: 0 start, 1 clear
  logic b_p1[2], b_p2[2], b_acc[2], b_accq[2];
  int   b_diff[2];

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic btn_upd(input int i, input logic raw,
                         input logic rs);
    if (rs) begin
      b_p1[i] = 0; b_p2[i] = 0; b_acc[i] = 0;
      b_accq[i] = 0; b_diff[i] = 0;
    end else begin
      b_accq[i] = b_acc[i];
      if (b_p2[i] != b_acc[i]) begin
        b_diff[i]++;
        if (b_diff[i] == DEB_LEN) begin
          b_acc[i]  = b_p2[i];
          b_diff[i] = 0;
        end
      end else begin
        b_diff[i] = 0;
      end
      b_p2[i] = b_p1[i];
      b_p1[i] = raw;
    end
  endtask

  task automatic step();
    logic       rs, si, ci, sp, cp, tick, nen;
    logic [3:0] cn;
    int         nmd;
    rs = RESET; si = START; ci = CLR; cn = cnt_m;
    sp = b_acc[0] & ~b_accq[0];
    cp = b_acc[1] & ~b_accq[1];
    @(posedge CLOCK);
    #1;
    cyc++;
    if (e_ld)      cnt_m = rsw;
    else if (e_en) cnt_m = (cnt_m == 4'd0) ? 4'd9 : cnt_m - 4'd1;
    btn_upd(0, si, rs);
    btn_upd(1, ci, rs);
    tick = (md == 1 && run_clk % DIV == DIV - 1)
        || (md == 3 && alm_clk % DIV == DIV - 1);
    nen = !rs && !cp && md == 1 && tick && cn != 4'd0;
    nmd = md;
    if (rs || cp) nmd = 0;
    else begin
      case (md)
        0: if (sp) nmd = 1;
        1: begin
`ifdef CNTDOWN_PAUSE_EN
          if (sp) nmd = 2;
          else if (tick && cn == 4'd0) nmd = 3;
`else
          if (tick && cn == 4'd0) nmd = 3;
`endif
        end
        2: if (sp) nmd = 1;
        3: begin
          if (sp) nmd = 0;
          else if (tick && alm_clk / DIV + 1 == ALARM_TICKS) nmd = 0;
        end
        default: nmd = 0;
      endcase
    end
    if (md == 1) run_clk++;
    if (md == 0 || rs) run_clk = 0;
    if (md == 3) alm_clk++;
    if ((nmd == 3 && md != 3) || rs) alm_clk = 0;
    md   = nmd;
    e_ld = (md == 0);
    e_rn = (md == 1);
    e_bz = (md == 3) && ((alm_clk / DIV) % 2 == 0);
    e_en = nen;
    chk("LD", LD, e_ld);
    chk("EN", EN, e_en);
    chk("BUZZ", BUZZ, e_bz);
    chk("RUNNING", RUNNING, e_rn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic s, input logic c, input int hold);
    START = s;
    CLR   = c;
    idle(hold);
    START = 1'b0;
    CLR   = 1'b0;
    idle(DEB_LEN + 4);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 2; i++) begin
      b_p1[i] = 0; b_p2[i] = 0; b_acc[i] = 0;
      b_accq[i] = 0; b_diff[i] = 0;
    end

    RESET = 1'b1;
    idle(3);
    RESET = 1'b0;
    chk("reset_ld", LD, 1'b1);
    chk("reset_en", EN, 1'b0);

    // full countdown from 3, alarm, back to idle
    rsw = 4'd3;
    idle(2);
    press(1'b1, 1'b0, DEB_LEN + 1);
    idle(60);
    chk("back_idle_ld", LD, 1'b1);

    // start from zero alarms at the first tick
    rsw = 4'd0;
    press(1'b1, 1'b0, DEB_LEN);
    idle(30);

    // pause/resume at count 2
    rsw = 4'($urandom_range(4, 9));
    press(1'b1, 1'b0, DEB_LEN + 2);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (md == 1 && cnt_m == 4'd2) found = 1;
      else step();
    end
    chk("wait_cnt2", found, 1'b1);
    press(1'b1, 1'b0, DEB_LEN);
    idle(20);
    press(1'b1, 1'b0, DEB_LEN);
    idle(40);

    // clear and start together while running
    rsw = 4'd7;
    press(1'b1, 1'b0, DEB_LEN);
    idle(5);
    press(1'b1, 1'b1, DEB_LEN + 1);
    chk("clr_start_ld", LD, 1'b1);

    // short glitch must not start the timer
    press(1'b1, 1'b0, 1);
    idle(10);
    chk("glitch_ld", LD, 1'b1);

    // reset in the tick cycle suppresses the EN
    rsw = 4'd5;
    press(1'b1, 1'b0, DEB_LEN);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (md == 1 && run_clk % DIV == DIV - 1 && cnt_m != 4'd0)
        found = 1;
      else step();
    end
    chk("wait_tick", found, 1'b1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("rst_en", EN, 1'b0);
    chk("rst_ld", LD, 1'b1);
    idle(4);

    // random button traffic and switch values
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       idle($urandom_range(1, 12));
      else if (r < 7)  press(1'b1, 1'b0, $urandom_range(1, 4));
      else if (r == 7) press(1'b0, 1'b1, $urandom_range(1, 4));
      else if (r == 8) rsw = 4'($urandom_range(0, 15));
      else             press(1'b1, 1'b1, $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
